// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Multiplexed N-digit 7-segment scanner. Each digit gets one slot of
//   2**SLOT_LOG2 clocks. The first BLANK_CYCLES of every slot are dark to stop
//   ghosting between digits. The rest of the slot is PWM-dimmed by brightness.
//   The display value is double-buffered: load writes the shadow registers, and
//   the active registers pick up the shadow only at a frame boundary. This keeps
//   a frame from showing a mix of old and new digits.
//
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   value       4*N_DIGITS nibbles, digit 0 = value[3:0]
//   dp          per-digit decimal point enable
//   load        strobe, captures value/dp into the shadow registers
//   blank_lz    1 = blank leading-zero digits (live input)
//   dec_mode    1 = nibbles 10..15 render as a dash (live input)
//   brightness  PWM duty of the lit window, 0 = off (live input)
//   seg         segments, active high: a f b g c dp d e (bit 7 down to 0)
//   dig_n       digit select, active low
//   frame_start one-cycle pulse after the active registers update
module seg7_scan_driver #(
  parameter int N_DIGITS     = 4,
  parameter int SLOT_LOG2    = 12,
  parameter int BLANK_CYCLES = 16,
  parameter int PWM_BITS     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp,
  input  logic                  load,
  input  logic                  blank_lz,
  input  logic                  dec_mode,
  input  logic [PWM_BITS-1:0]   brightness,
  output logic [7:0]            seg,
  output logic [N_DIGITS-1:0]   dig_n,
  output logic                  frame_start
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [IDX_W-1:0]     LAST_DIG  = IDX_W'(N_DIGITS - 1);
  localparam logic [SLOT_LOG2-1:0] BLANK_END = SLOT_LOG2'(BLANK_CYCLES);

  logic [SLOT_LOG2-1:0]  slot_cnt;
  logic [IDX_W-1:0]      dig_idx;
  logic [4*N_DIGITS-1:0] shadow_value;
  logic [N_DIGITS-1:0]   shadow_dp;
  logic [4*N_DIGITS-1:0] active_value;
  logic [N_DIGITS-1:0]   active_dp;

  logic                  frame;
  logic                  lit;
  logic [3:0]            nib [N_DIGITS];
  logic [N_DIGITS-1:0]   upper_zero;
  logic                  zero_acc;
  logic [3:0]            cur_nib;
  logic                  cur_blank;
  logic [7:0]            seg_next;
  logic [N_DIGITS-1:0]   dig_onehot;

  function automatic logic [7:0] glyph_of(input logic [3:0] n, input logic dec);
    logic [7:0] g;
    case (n)
      4'h0:    g = 8'hEB;
      4'h1:    g = 8'h28;
      4'h2:    g = 8'hB3;
      4'h3:    g = 8'hBA;
      4'h4:    g = 8'h78;
      4'h5:    g = 8'hDA;
      4'h6:    g = 8'hDB;
      4'h7:    g = 8'hA8;
      4'h8:    g = 8'hFB;
      4'h9:    g = 8'hFA;
      4'hA:    g = 8'hF9;
      4'hB:    g = 8'h5B;
      4'hC:    g = 8'hC3;
      4'hD:    g = 8'h3B;
      4'hE:    g = 8'hD3;
      default: g = 8'hD1;
    endcase
    // In decimal mode all non-decimal nibbles show as a dash (segment g).
    if (dec && (n > 4'd9)) g = 8'h10;
    return g;
  endfunction

  // The frame boundary is the first cycle of digit 0's slot.
  assign frame = (dig_idx == '0) && (slot_cnt == '0);

  // The lit window follows the blanking dead-time. The top PWM_BITS of the slot
  // counter form a ramp, and brightness is compared against that ramp.
  assign lit = (slot_cnt >= BLANK_END) &&
               (slot_cnt[SLOT_LOG2-1 -: PWM_BITS] < brightness);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt <= '0;
      dig_idx  <= '0;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
      if (&slot_cnt) begin
        dig_idx <= (dig_idx == LAST_DIG) ? '0 : dig_idx + 1'b1;
      end
    end
  end

  // A load on the boundary cycle goes straight to the active registers, so it
  // is shown in the frame that is starting. It still writes the shadow too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_value <= '0;
      shadow_dp    <= '0;
      active_value <= '0;
      active_dp    <= '0;
    end else begin
      if (load) begin
        shadow_value <= value;
        shadow_dp    <= dp;
      end
      if (frame) begin
        active_value <= load ? value : shadow_value;
        active_dp    <= load ? dp    : shadow_dp;
      end
    end
  end

  // upper_zero[i] is set when nibbles i..N_DIGITS-1 are all zero. This is the
  // leading-zero condition for digit i.
  always_comb begin
    zero_acc   = 1'b1;
    upper_zero = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      nib[i] = active_value[4*i +: 4];
    end
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zero_acc      = zero_acc && (nib[i] == 4'h0);
      upper_zero[i] = zero_acc;
    end
  end

  always_comb begin
    cur_nib   = nib[dig_idx];
    cur_blank = blank_lz && (dig_idx != '0) && upper_zero[dig_idx];
    seg_next  = cur_blank ? 8'h00 : glyph_of(cur_nib, dec_mode);
    // The decimal point is shown even on a blanked digit.
    seg_next[2] = seg_next[2] | active_dp[dig_idx];
    dig_onehot  = '0;
    dig_onehot[dig_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg         <= 8'h00;
      dig_n       <= '1;
      frame_start <= 1'b0;
    end else begin
      seg         <= lit ? seg_next : 8'h00;
      dig_n       <= lit ? ~dig_onehot : '1;
      frame_start <= frame;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver
//   Frame-level scoreboard bench for seg7_scan_driver (4 digits, 64-clock slots).
//   The stimulus pushes the expected per-digit glyph and lit-cycle count for
//   each frame it drives. A monitor accumulates what the pins show between two
//   frame_start pulses, then pops the matching entry and compares.
module tb_seg7_scan_driver;

  localparam int N_DIGITS     = 4;
  localparam int SLOT_LOG2    = 6;
  localparam int BLANK_CYCLES = 4;
  localparam int PWM_BITS     = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        load;
  logic        blank_lz;
  logic        dec_mode;
  logic [3:0]  brightness;
  logic [7:0]  seg;
  logic [3:0]  dig_n;
  logic        frame_start;

  typedef struct packed {
    int unsigned frame;
    logic [31:0] segs;
    logic [7:0]  lit;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cur_frame = 0;
  int          lit_cnt [4];
  logic [7:0]  obs_seg [4];
  bit          dirty = 1'b0;
  bit          skip = 1'b1;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .N_DIGITS(N_DIGITS),
    .SLOT_LOG2(SLOT_LOG2),
    .BLANK_CYCLES(BLANK_CYCLES),
    .PWM_BITS(PWM_BITS)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .value(value),
    .dp(dp),
    .load(load),
    .blank_lz(blank_lz),
    .dec_mode(dec_mode),
    .brightness(brightness),
    .seg(seg),
    .dig_n(dig_n),
    .frame_start(frame_start)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic clearAcc();
    for (int d = 0; d < 4; d++) begin
      lit_cnt[d] = 0;
      obs_seg[d] = 8'h00;
    end
    dirty = 1'b0;
  endtask

  task automatic finalizeFrame(input int f);
    exp_t e;
    logic [7:0] es;
    while (sb.size() > 0 && sb[0].frame < f) begin
      e = sb.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL frame %0d not observed: expectation still queued at frame %0d", e.frame, f);
    end
    if (sb.size() > 0 && sb[0].frame == f) begin
      e = sb.pop_front();
      for (int d = 0; d < 4; d++) begin
        es = e.segs[8*d +: 8];
        checks++;
        if (lit_cnt[d] != int'(e.lit) || (e.lit != 0 && obs_seg[d] !== es)) begin
          errors++;
          $display("[TB] FAIL frame %0d digit %0d: got seg=%h lit=%0d, expected seg=%h lit=%0d",
                   f, d, obs_seg[d], lit_cnt[d], es, e.lit);
        end
      end
      checks++;
      if (dirty) begin
        errors++;
        $display("[TB] FAIL frame %0d pins: got unstable seg, bad dig_n or seg while dark, expected clean scan", f);
      end
    end
  endtask

  // Monitor: samples on the falling edge, away from the registered outputs.
  always @(negedge clk) begin
    logic [3:0] oh;
    int found;
    if (!rst_n) begin
      clearAcc();
      skip = 1'b1;
    end else if (frame_start) begin
      if (!skip) finalizeFrame(cur_frame);
      skip = 1'b0;
      clearAcc();
      cur_frame++;
    end else if (dig_n == 4'hF) begin
      if (seg != 8'h00) dirty = 1'b1;
    end else begin
      found = -1;
      for (int d = 0; d < 4; d++) begin
        oh = 4'b0001 << d;
        if (dig_n == ~oh) found = d;
      end
      if (found < 0) begin
        dirty = 1'b1;
      end else begin
        if (lit_cnt[found] == 0) obs_seg[found] = seg;
        else if (obs_seg[found] !== seg) dirty = 1'b1;
        lit_cnt[found]++;
      end
    end
  end

  task automatic syncFrame();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_start !== 1'b1 && n < 1000);
    if (frame_start !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL frame_start timeout: got no pulse in %0d cycles, expected one per 256", n);
    end
    #1;
  endtask

  // Called right after a frame_start. Sets the live inputs for this frame and
  // queues its expectation. Optionally issues a load:
  //   ld_mode 1 = mid-frame load, 2 = load on the next frame-boundary cycle.
  task automatic applyStimulus(input logic [15:0] v, input logic [3:0] d, input int ld_mode,
                               input logic [3:0] br, input logic dm, input logic lz,
                               input logic [31:0] exp_segs, input logic [7:0] exp_lit);
    exp_t e;
    brightness = br;
    dec_mode   = dm;
    blank_lz   = lz;
    e.frame = cur_frame;
    e.segs  = exp_segs;
    e.lit   = exp_lit;
    sb.push_back(e);
    if (ld_mode == 1) begin
      repeat (100) @(posedge clk);
      #1 value = v; dp = d; load = 1'b1;
      @(posedge clk);
      #1 load = 1'b0;
    end else if (ld_mode == 2) begin
      repeat (255) @(posedge clk);
      #1 value = v; dp = d; load = 1'b1;
      @(posedge clk);
      #1 load = 1'b0;
    end
    syncFrame();
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; value = 16'h0000; dp = 4'h0;
    blank_lz = 1'b0; dec_mode = 1'b0; brightness = 4'd15;
    repeat (3) @(negedge clk);
    checkOutput("reset seg", 32'(seg), 32'h00);
    checkOutput("reset dig_n", 32'(dig_n), 32'hF);
    checkOutput("reset frame_start", 32'(frame_start), 32'h0);
    rst_n = 1'b1;
    syncFrame();

    repeat (20) @(posedge clk);
    #2;
    checkOutput("digit0 lit before reset seg", 32'(seg), 32'hEB);
    checkOutput("digit0 lit before reset dig_n", 32'(dig_n), 32'hE);
    rst_n = 1'b0;
    #1;
    checkOutput("mid-scan reset seg", 32'(seg), 32'h00);
    checkOutput("mid-scan reset dig_n", 32'(dig_n), 32'hF);
    checkOutput("mid-scan reset frame_start", 32'(frame_start), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("first frame_start after release", 32'(frame_start), 32'h1);
    syncFrame();

    //            value     dp    ld  br  dm  lz  expected {d3,d2,d1,d0}  lit
    applyStimulus(16'h1234, 4'h0, 2, 15, 0, 0, 32'hEB_EB_EB_EB, 8'd56);
    applyStimulus(16'h0000, 4'h0, 0, 15, 0, 0, 32'h28_B3_BA_78, 8'd56);
    applyStimulus(16'h0000, 4'h0, 0,  8, 0, 0, 32'h28_B3_BA_78, 8'd28);
    applyStimulus(16'h0000, 4'h0, 0,  0, 0, 0, 32'h28_B3_BA_78, 8'd0);
    applyStimulus(16'h5678, 4'h0, 1, 15, 0, 0, 32'h28_B3_BA_78, 8'd56);
    applyStimulus(16'h00AF, 4'h0, 2, 15, 0, 0, 32'hDA_DB_A8_FB, 8'd56);
    applyStimulus(16'h0000, 4'h0, 0, 15, 0, 0, 32'hEB_EB_F9_D1, 8'd56);
    applyStimulus(16'h0070, 4'h0, 2, 15, 1, 0, 32'hEB_EB_10_10, 8'd56);
    applyStimulus(16'h0000, 4'h4, 2, 15, 0, 1, 32'h00_00_A8_EB, 8'd56);
    applyStimulus(16'h0000, 4'h0, 0, 15, 0, 1, 32'h00_04_00_EB, 8'd56);
    applyStimulus(16'h0000, 4'h0, 0, 15, 0, 0, 32'hEB_EF_EB_EB, 8'd56);

    checkOutput("scoreboard drained", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
